// File: rtl/tcp_rx_route_demux_if.sv
// Stream bundle between the TCP RX arbiter output and the per-vFPGA region streams.
// slave is the demux view; master is the view of the logic driving and draining it.
interface tcp_rx_route_demux_if #(
    parameter int N_REGIONS = 4,
    parameter int DATA_BITS = 512
);
    logic                            s_axis_tvalid;
    logic                            s_axis_tready;
    logic [DATA_BITS-1:0]            s_axis_tdata;
    logic [DATA_BITS/8-1:0]          s_axis_tkeep;
    logic                            s_axis_tlast;
    logic [13:0]                     s_axis_tdest;

    logic [N_REGIONS-1:0]            m_axis_tvalid;
    logic [N_REGIONS-1:0]            m_axis_tready;
    logic [N_REGIONS*DATA_BITS-1:0]  m_axis_tdata;
    logic [N_REGIONS*DATA_BITS/8-1:0] m_axis_tkeep;
    logic [N_REGIONS-1:0]            m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tdest,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tdest,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/tcp_rx_route_demux.sv
// Routes each packet of the TCP RX stream to its receiver region via a 1-deep output register.
// Optional per-region packet counters are enabled with TCP_RX_DEMUX_PKT_CNT_EN.
module tcp_rx_route_demux #(
    parameter int N_REGIONS     = 4,
    parameter int DATA_BITS     = 512,
    parameter int DROP_CNT_BITS = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    tcp_rx_route_demux_if.slave      bus,
    output logic [3:0]               cur_route,
    output logic [DROP_CNT_BITS-1:0] drop_cnt
`ifdef TCP_RX_DEMUX_PKT_CNT_EN
    ,
    output logic [N_REGIONS*32-1:0]  pkt_cnt
`endif
);
    localparam int KEEP_BITS = DATA_BITS / 8;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                         state_q, state_d;
    logic [3:0]                     curRoute_q, curRoute_d;
    logic [DROP_CNT_BITS-1:0]       dropCnt_q, dropCnt_d;

    logic [N_REGIONS-1:0]           mValid_q;
    logic [N_REGIONS*DATA_BITS-1:0] mData_q;
    logic [N_REGIONS*KEEP_BITS-1:0] mKeep_q;
    logic [N_REGIONS-1:0]           mLast_q;

    logic [3:0]                     rxId;
    logic                           rxLegal;
    logic [3:0]                     target;
    logic                           fwdBeat;
    logic                           targetFree;
    logic                           sReady;
    logic                           inHandshake;
    logic [N_REGIONS-1:0]           slotFree;
    logic [N_REGIONS-1:0]           load;
    logic                           unusedTdest;

    assign rxId        = bus.s_axis_tdest[5:2];
    assign rxLegal     = ({1'b0, rxId} < 5'(N_REGIONS));
    assign slotFree    = ~mValid_q | bus.m_axis_tready;
    assign unusedTdest = ^{bus.s_axis_tdest[13:6], bus.s_axis_tdest[1:0]};

    // Route selection, input ready and packet-level state; the route is locked after the first beat.
    always_comb begin
        state_d     = state_q;
        curRoute_d  = curRoute_q;
        dropCnt_d   = dropCnt_q;
        target      = rxId;
        fwdBeat     = 1'b0;
        targetFree  = 1'b0;
        load        = '0;

        unique case (state_q)
            IDLE:    fwdBeat = rxLegal;
            FWD: begin
                fwdBeat = 1'b1;
                target  = curRoute_q;
            end
            default: fwdBeat = 1'b0;
        endcase

        for (int i = 0; i < N_REGIONS; i++) begin
            if (target == 4'(i)) targetFree = slotFree[i];
        end

        sReady      = aresetn && (fwdBeat ? targetFree : 1'b1);
        inHandshake = bus.s_axis_tvalid && sReady;

        if (inHandshake) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                load[i] = fwdBeat && (target == 4'(i));
            end

            unique case (state_q)
                IDLE: begin
                    if (rxLegal) begin
                        if (!bus.s_axis_tlast) begin
                            curRoute_d = rxId;
                            state_d    = FWD;
                        end
                    end else begin
                        if (dropCnt_q != '1) dropCnt_d = dropCnt_q + DROP_CNT_BITS'(1);
                        if (!bus.s_axis_tlast) state_d = DROP;
                    end
                end
                FWD: begin
                    if (bus.s_axis_tlast) begin
                        state_d    = IDLE;
                        curRoute_d = 4'd0;
                    end
                end
                default: begin
                    if (bus.s_axis_tlast) state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            curRoute_q <= 4'd0;
            dropCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            curRoute_q <= curRoute_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // A slot reloads in the same cycle it drains, so a ready consumer sees no bubble.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mValid_q <= '0;
            mData_q  <= '0;
            mKeep_q  <= '0;
            mLast_q  <= '0;
        end else begin
            for (int i = 0; i < N_REGIONS; i++) begin
                if (load[i]) begin
                    mValid_q[i]                          <= 1'b1;
                    mData_q[i*DATA_BITS +: DATA_BITS]    <= bus.s_axis_tdata;
                    mKeep_q[i*KEEP_BITS +: KEEP_BITS]    <= bus.s_axis_tkeep;
                    mLast_q[i]                           <= bus.s_axis_tlast;
                end else if (bus.m_axis_tready[i]) begin
                    mValid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.s_axis_tready = sReady;
    assign bus.m_axis_tvalid = mValid_q;
    assign bus.m_axis_tdata  = mData_q;
    assign bus.m_axis_tkeep  = mKeep_q;
    assign bus.m_axis_tlast  = mLast_q;
    assign cur_route         = curRoute_q;
    assign drop_cnt          = dropCnt_q;

`ifdef TCP_RX_DEMUX_PKT_CNT_EN
    logic [N_REGIONS*32-1:0] pktCnt_q;

    // Counts packets as their last beat leaves each output register; wraps freely.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pktCnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REGIONS; i++) begin
                if (mValid_q[i] && bus.m_axis_tready[i] && mLast_q[i]) begin
                    pktCnt_q[i*32 +: 32] <= pktCnt_q[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign pkt_cnt = pktCnt_q;
`endif

endmodule

// File: tb/tb_tcp_rx_route_demux.sv
// Table-driven bench for tcp_rx_route_demux with 4 regions and 32-bit data.
// Each table row is one cycle: inputs driven after negedge, outputs checked before the next posedge.
module tb_tcp_rx_route_demux;
    localparam int NR = 4;
    localparam int DW = 32;

    typedef struct {
        logic        vld;
        logic [13:0] dest;
        logic        last;
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  mrdy;
        logic        expRdy;
        logic [3:0]  expValid;
        logic [3:0]  expLast;
        int          expRoute;
        logic [31:0] expDrop;
        int          expReg;
        logic [31:0] expData;
        logic [3:0]  expKeep;
    } vec_t;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  curRoute;
    logic [31:0] dropCnt;
`ifdef TCP_RX_DEMUX_PKT_CNT_EN
    logic [NR*32-1:0] pktCnt;
`endif

    int testsRun;
    int testsFailed;
    vec_t vecs[$];

    tcp_rx_route_demux_if #(.N_REGIONS(NR), .DATA_BITS(DW)) bus ();

    tcp_rx_route_demux #(.N_REGIONS(NR), .DATA_BITS(DW), .DROP_CNT_BITS(32)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .bus      (bus),
        .cur_route(curRoute),
        .drop_cnt (dropCnt)
`ifdef TCP_RX_DEMUX_PKT_CNT_EN
        ,
        .pkt_cnt  (pktCnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic vec_t mk(logic vld, logic [13:0] dest, logic last, logic [31:0] data,
                                logic [3:0] keep, logic [3:0] mrdy, logic expRdy,
                                logic [3:0] expValid, logic [3:0] expLast, int expRoute,
                                logic [31:0] expDrop, int expReg, logic [31:0] expData,
                                logic [3:0] expKeep);
        vec_t v;
        v.vld = vld; v.dest = dest; v.last = last; v.data = data; v.keep = keep; v.mrdy = mrdy;
        v.expRdy = expRdy; v.expValid = expValid; v.expLast = expLast; v.expRoute = expRoute;
        v.expDrop = expDrop; v.expReg = expReg; v.expData = expData; v.expKeep = expKeep;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [13:0] dest, input logic last,
                                 input logic [31:0] data, input logic [3:0] keep, input logic [3:0] mrdy);
        bus.s_axis_tvalid = vld;
        bus.s_axis_tdest  = dest;
        bus.s_axis_tlast  = last;
        bus.s_axis_tdata  = data;
        bus.s_axis_tkeep  = keep;
        bus.m_axis_tready = mrdy;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        aresetn     = 1'b0;
        applyStimulus(1'b0, 14'h0, 1'b0, 32'h0, 4'hF, 4'hF);

        // 3-beat packet to region 2
        vecs.push_back(mk(1, 14'h0008, 0, 32'hA1, 4'hF, 4'hF, 1, 4'b0000, 4'b0000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(1, 14'h0008, 0, 32'hA2, 4'hF, 4'hF, 1, 4'b0100, 4'b0000, 2, 0, 2, 32'hA1, 4'hF));
        vecs.push_back(mk(1, 14'h0008, 1, 32'hA3, 4'hF, 4'hF, 1, 4'b0100, 4'b0000, 2, 0, 2, 32'hA2, 4'hF));
        vecs.push_back(mk(0, 14'h0000, 0, 32'h00, 4'hF, 4'hF, 1, 4'b0100, 4'b0100, 0, 0, 2, 32'hA3, 4'hF));
        // route locked to region 1 although tdest changes to rid 3
        vecs.push_back(mk(1, 14'h0004, 0, 32'hB1, 4'hF, 4'hF, 1, 4'b0000, 4'b0000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(1, 14'h000C, 0, 32'hB2, 4'hF, 4'hF, 1, 4'b0010, 4'b0000, 1, 0, 1, 32'hB1, 4'hF));
        vecs.push_back(mk(1, 14'h000C, 0, 32'hB3, 4'hF, 4'hF, 1, 4'b0010, 4'b0000, 1, 0, 1, 32'hB2, 4'hF));
        vecs.push_back(mk(1, 14'h000C, 1, 32'hB4, 4'hF, 4'hF, 1, 4'b0010, 4'b0000, 1, 0, 1, 32'hB3, 4'hF));
        vecs.push_back(mk(0, 14'h0000, 0, 32'h00, 4'hF, 4'hF, 1, 4'b0010, 4'b0010, 0, 0, 1, 32'hB4, 4'hF));
        // rid 12 is illegal: dropped, ready even with outputs stalled
        vecs.push_back(mk(1, 14'h0030, 0, 32'hC1, 4'hF, 4'hF, 1, 4'b0000, 4'b0000, 0, 0, -1, 0, 0));
        vecs.push_back(mk(1, 14'h0030, 1, 32'hC2, 4'hF, 4'h0, 1, 4'b0000, 4'b0000, 0, 1, -1, 0, 0));
        vecs.push_back(mk(0, 14'h0000, 0, 32'h00, 4'hF, 4'hF, 1, 4'b0000, 4'b0000, 0, 1, -1, 0, 0));
        // region 0 back-pressured for 5 cycles
        vecs.push_back(mk(1, 14'h0000, 0, 32'hD1, 4'hF, 4'hF, 1, 4'b0000, 4'b0000, 0, 1, -1, 0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 14'h0000, 0, 32'hD2, 4'hF, 4'h0, 0, 4'b0001, 4'b0000, 0, 1, 0, 32'hD1, 4'hF));
        vecs.push_back(mk(1, 14'h0000, 0, 32'hD2, 4'hF, 4'hF, 1, 4'b0001, 4'b0000, 0, 1, 0, 32'hD1, 4'hF));
        vecs.push_back(mk(1, 14'h0000, 1, 32'hD3, 4'hF, 4'hF, 1, 4'b0001, 4'b0000, 0, 1, 0, 32'hD2, 4'hF));
        vecs.push_back(mk(0, 14'h0000, 0, 32'h00, 4'hF, 4'hF, 1, 4'b0001, 4'b0001, 0, 1, 0, 32'hD3, 4'hF));
        // back-to-back single-beat packets to 0,1,0; the middle one has zero tkeep
        vecs.push_back(mk(1, 14'h0000, 1, 32'hE1, 4'hF, 4'hF, 1, 4'b0000, 4'b0000, 0, 1, -1, 0, 0));
        vecs.push_back(mk(1, 14'h0004, 1, 32'hE2, 4'h0, 4'hF, 1, 4'b0001, 4'b0001, -1, 1, 0, 32'hE1, 4'hF));
        vecs.push_back(mk(1, 14'h0000, 1, 32'hE3, 4'hF, 4'hF, 1, 4'b0010, 4'b0010, -1, 1, 1, 32'hE2, 4'h0));
        vecs.push_back(mk(0, 14'h0000, 0, 32'h00, 4'hF, 4'hF, 1, 4'b0001, 4'b0001, -1, 1, 0, 32'hE3, 4'hF));

        // reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        applyStimulus(1'b1, 14'h0008, 1'b0, 32'h55, 4'hF, 4'hF);
        #1;
        checkOutput("reset.srdy",   64'(bus.s_axis_tready), 64'd0);
        checkOutput("reset.mvalid", 64'(bus.m_axis_tvalid), 64'd0);
        checkOutput("reset.route",  64'(curRoute), 64'd0);
        checkOutput("reset.drop",   64'(dropCnt), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        applyStimulus(1'b0, 14'h0, 1'b0, 32'h0, 4'hF, 4'hF);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge aclk);
            applyStimulus(vecs[i].vld, vecs[i].dest, vecs[i].last, vecs[i].data, vecs[i].keep, vecs[i].mrdy);
            #1;
            checkOutput($sformatf("v%0d.srdy", i), 64'(bus.s_axis_tready), 64'(vecs[i].expRdy));
            checkOutput($sformatf("v%0d.mvalid", i), 64'(bus.m_axis_tvalid), 64'(vecs[i].expValid));
            checkOutput($sformatf("v%0d.mlast", i), 64'(bus.m_axis_tlast & bus.m_axis_tvalid), 64'(vecs[i].expLast));
            checkOutput($sformatf("v%0d.drop", i), 64'(dropCnt), 64'(vecs[i].expDrop));
            if (vecs[i].expRoute >= 0)
                checkOutput($sformatf("v%0d.route", i), 64'(curRoute), 64'(vecs[i].expRoute));
            if (vecs[i].expReg >= 0) begin
                checkOutput($sformatf("v%0d.data", i),
                            64'(bus.m_axis_tdata[vecs[i].expReg*DW +: DW]), 64'(vecs[i].expData));
                checkOutput($sformatf("v%0d.keep", i),
                            64'(bus.m_axis_tkeep[vecs[i].expReg*4 +: 4]), 64'(vecs[i].expKeep));
            end
        end

`ifdef TCP_RX_DEMUX_PKT_CNT_EN
        @(posedge aclk);
        #1;
        checkOutput("pktcnt.r0", 64'(pktCnt[0*32 +: 32]), 64'd3);
        checkOutput("pktcnt.r1", 64'(pktCnt[1*32 +: 32]), 64'd2);
        checkOutput("pktcnt.r2", 64'(pktCnt[2*32 +: 32]), 64'd1);
        checkOutput("pktcnt.r3", 64'(pktCnt[3*32 +: 32]), 64'd0);
`endif

        // reset in the middle of a 4-beat packet to region 1
        @(negedge aclk);
        applyStimulus(1'b1, 14'h0004, 1'b0, 32'hF1, 4'hF, 4'hF);
        #1;
        checkOutput("mid.b1.srdy", 64'(bus.s_axis_tready), 64'd1);
        @(negedge aclk);
        applyStimulus(1'b1, 14'h0004, 1'b0, 32'hF2, 4'hF, 4'hF);
        #1;
        checkOutput("mid.b2.route", 64'(curRoute), 64'd1);
        checkOutput("mid.b2.data",  64'(bus.m_axis_tdata[1*DW +: DW]), 64'h0F1);
        @(negedge aclk);
        aresetn = 1'b0;
        applyStimulus(1'b1, 14'h0004, 1'b0, 32'hF3, 4'hF, 4'hF);
        #1;
        checkOutput("mid.rst.srdy",   64'(bus.s_axis_tready), 64'd0);
        checkOutput("mid.rst.mvalid", 64'(bus.m_axis_tvalid), 64'b0010);
        @(negedge aclk);
        aresetn = 1'b1;
        applyStimulus(1'b0, 14'h0004, 1'b0, 32'h0, 4'hF, 4'hF);
        #1;
        checkOutput("post.mvalid", 64'(bus.m_axis_tvalid), 64'd0);
        checkOutput("post.route",  64'(curRoute), 64'd0);
        checkOutput("post.drop",   64'(dropCnt), 64'd0);
`ifdef TCP_RX_DEMUX_PKT_CNT_EN
        checkOutput("post.pktcnt", 64'(|pktCnt), 64'd0);
`endif
        @(negedge aclk);
        applyStimulus(1'b1, 14'h000C, 1'b1, 32'h33, 4'hF, 4'hF);
        #1;
        checkOutput("post.b1.srdy", 64'(bus.s_axis_tready), 64'd1);
        @(negedge aclk);
        applyStimulus(1'b0, 14'h0000, 1'b0, 32'h0, 4'hF, 4'hF);
        #1;
        checkOutput("post.b1.mvalid", 64'(bus.m_axis_tvalid), 64'b1000);
        checkOutput("post.b1.mlast",  64'(bus.m_axis_tlast[3]), 64'd1);
        checkOutput("post.b1.data",   64'(bus.m_axis_tdata[3*DW +: DW]), 64'h33);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
